p16_fp32_conv_arbiter: RTL and testbench
========================================

Name: p16_fp32_conv_arbiter

Overview:
- Shares one combinational posit<16,0> to fp32 conversion unit among NREQ requesters.
- Round-robin arbitration over valid/ready request ports.
- Registered single-entry output stage with backpressure; each result is tagged with the index of the requester that produced it.
- Sits between vector/scalar posit producers and fp32 consumers in the PPU datapath.

Parameters:
- NREQ, 4, number of requester ports (2..8).
- IDW, 2, requester-id width; equals clog2(NREQ) and is at least 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_p16  in  16*NREQ  posit operands; requester i occupies bits [16i+15:16i].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accept.
- out_fp32  out  32  converted fp32 result.
- out_id  out  IDW  index of the requester that produced out_fp32.
- busy  out  1  high when out_valid=1 or any req_valid=1.

Behaviour:
- Reset (rst=1 at an edge):
  - out_valid=0, out_fp32=0, out_id=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready is 0 during the reset cycle.
  - Reset mid-transfer discards any held result without delivering it.
- Output stage is one register slot. load = (!out_valid || out_ready) && |req_valid.
- Arbitration, combinational in the same cycle:
  - Search from rr_ptr upward, wrapping modulo NREQ.
  - The first i with req_valid[i]=1 is the grant g.
  - req_ready = onehot(g) when load=1, else 0.
  - Handshake completes for requester g when req_valid[g] && req_ready[g].
- Conversion:
  - req_p16[g] drives the single shared converter instance.
  - Converter output is registered into out_fp32 on load; out_id <= g.
  - Latency is exactly 1 cycle from request handshake to out_valid=1.
- Pointer update: on load, rr_ptr <= (g+1) mod NREQ. Otherwise rr_ptr holds.
- out_valid register:
  - load=1: out_valid <= 1.
  - load=0 and out_ready=1: out_valid <= 0.
  - Otherwise hold.
- Backpressure: while out_valid=1 and out_ready=0:
  - req_ready=0.
  - out_fp32 and out_id are held stable.
- Simultaneous out_ready and new grant in the same cycle: the result is consumed and the next result is loaded. Sustained throughput is 1 result/cycle.
- Fairness: with all requesters continuously valid, grants cycle 0,1,...,NREQ-1,0,... Each requester waits at most NREQ-1 grants.
- Requesters must hold req_valid and req_p16 stable until accepted. Dropping req_valid before acceptance is legal; the requester is simply not granted.
- Converter semantics, posit<16,0> to IEEE-754 single:
  - sign = p16[15]; the magnitude is the two's complement of p16 when negative.
  - Exponent = k+127, where k is the regime value.
  - Fraction = posit fraction bits, left-aligned in fp32[22:15]; fp32[14:0]=0.
- Special inputs: 0x0000 and 0x8000 pass through the converter unchanged. The arbiter does not special-case them.
- rr_ptr arithmetic is modulo NREQ; NREQ need not be a power of two.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req_valid=4'hF -> req_ready=0, out_valid=0, out_fp32=0, out_id=0. First grant after release goes to requester 0.
- Single request: req_valid=4'b0100, req_p16[2]=0x4000, out_ready=1 -> req_ready=4'b0100 in cycle 0. Cycle 1: out_valid=1, out_fp32=0x3F800000, out_id=2.
- Round robin: all four valid continuously with p16 = 0x4000, 0xC000, 0x6000, 0x5000, out_ready=1 -> results on 4 consecutive cycles:
  - out_id 0 -> 0x3F800000
  - out_id 1 -> 0xBF800000
  - out_id 2 -> 0x40000000
  - out_id 3 -> 0x3FC00000
  - then out_id returns to 0.
- Backpressure: out_ready=0 for 5 cycles while out_valid=1 -> req_ready=0 and out_fp32/out_id stable throughout. Raise out_ready -> next result appears the following cycle, with no result lost or duplicated.
- Wrap and skip: rr_ptr=3, req_valid=4'b0010 -> grant goes to 1 and rr_ptr becomes 2. A later request from 0 and 1 together grants 0 first only if rr_ptr has wrapped past 1.
- Reset mid-operation: assert rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0, rr_ptr=0, and the held result is never delivered.

Source files
------------

// File: rtl/p16_fp32_conv_arbiter.sv
// Round-robin arbiter sharing one posit<16,0> -> fp32 converter among NREQ
// requesters, with a single registered output slot and valid/ready backpressure.
module p16_fp32_conv_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [16*NREQ-1:0] req_p16,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_fp32,
  output logic [IDW-1:0]     out_id,
  output logic               busy
);

  // Regime is the run of bits equal to body[14]; the bits after its terminator
  // are the fraction, truncated to the top 8 bits of the fp32 mantissa.
  function automatic logic [31:0] p16_to_fp32(input logic [15:0] p);
    logic [15:0] mag;
    logic [14:0] body;
    logic [14:0] frac;
    logic [4:0]  run;
    logic        done;
    logic [7:0]  expo;
    mag  = p[15] ? (~p + 16'd1) : p;
    body = mag[14:0];
    run  = 5'd1;
    done = 1'b0;
    for (int i = 13; i >= 0; i--) begin
      if (!done) begin
        if (body[i] == body[14]) run = run + 5'd1;
        else                     done = 1'b1;
      end
    end
    frac = body << (run + 5'd1);
    expo = body[14] ? (8'd126 + {3'b000, run}) : (8'd127 - {3'b000, run});
    if (p == 16'h0000)      p16_to_fp32 = 32'h0000_0000;
    else if (p == 16'h8000) p16_to_fp32 = 32'h7FC0_0000;
    else                    p16_to_fp32 = {p[15], expo, frac[14:7], 15'd0};
  endfunction

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] next_ptr;
  logic           found;
  logic           load;
  logic [15:0]    sel_p16;
  logic [31:0]    conv_fp32;

  // NOTE: every variable gets a default before the search loop so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    found = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = IDW'(idx);
      end
    end
  end

  // Reset gates load so nothing is accepted during the reset cycle.
  assign load      = !rst && (!out_valid || out_ready) && found;
  assign req_ready = load ? (NREQ'(1) << grant) : '0;
  assign sel_p16   = req_p16[16*grant +: 16];
  assign conv_fp32 = p16_to_fp32(sel_p16);
  assign next_ptr  = (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
  assign busy      = out_valid || (|req_valid);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_fp32  <= '0;
      out_id    <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_fp32  <= conv_fp32;
      out_id    <= grant;
      rr_ptr    <= next_ptr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_p16_fp32_conv_arbiter.sv
// Directed bench for p16_fp32_conv_arbiter: a cycle-by-cycle vector table
// plus hand-written sequences for a bounded grant wait and mid-transfer reset.
module tb_p16_fp32_conv_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int NV   = 22;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [16*NREQ-1:0] req_p16;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_fp32;
  logic [IDW-1:0]     out_id;
  logic               busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  p16_fp32_conv_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_p16(req_p16), .out_valid(out_valid), .out_ready(out_ready),
    .out_fp32(out_fp32), .out_id(out_id), .busy(busy)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  rv;
    logic [63:0] p;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic [31:0] e_fp;
    logic [1:0]  e_id;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input logic r, input logic [3:0] rv, input logic [63:0] p,
                              input logic ordy, input logic [3:0] e_rdy, input logic e_ov,
                              input logic [31:0] e_fp, input logic [1:0] e_id);
    vec_t v;
    v.rst = r; v.rv = rv; v.p = p; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_fp = e_fp; v.e_id = e_id;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] rv, input logic [63:0] p, input logic ordy);
    @(negedge clk);
    rst = r; req_valid = rv; req_p16 = p; out_ready = ordy;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] rr4;
    logic        prev_ov;
    logic        got;

    rst = 1'b1; req_valid = '0; req_p16 = '0; out_ready = 1'b1;
    rr4 = {16'h5000, 16'h6000, 16'hC000, 16'h4000};

    // reset held two cycles with all requesters valid
    vecs[0]  = mk(1, 4'hF, {4{16'h4000}}, 1, 4'b0000, 0, 32'h0, 2'd0);
    vecs[1]  = mk(1, 4'hF, {4{16'h4000}}, 1, 4'b0000, 0, 32'h0, 2'd0);
    // round robin, one result per cycle, then back to 0
    vecs[2]  = mk(0, 4'hF, rr4, 1, 4'b0001, 1, 32'h3F80_0000, 2'd0);
    vecs[3]  = mk(0, 4'hF, rr4, 1, 4'b0010, 1, 32'hBF80_0000, 2'd1);
    vecs[4]  = mk(0, 4'hF, rr4, 1, 4'b0100, 1, 32'h4000_0000, 2'd2);
    vecs[5]  = mk(0, 4'hF, rr4, 1, 4'b1000, 1, 32'h3FC0_0000, 2'd3);
    vecs[6]  = mk(0, 4'hF, rr4, 1, 4'b0001, 1, 32'h3F80_0000, 2'd0);
    // single request from 2 (ptr=1)
    vecs[7]  = mk(0, 4'b0100, {16'h0, 16'h4000, 16'h0, 16'h0}, 1, 4'b0100, 1, 32'h3F80_0000, 2'd2);
    // ptr=3, only 1 valid: wrap and skip, zero operand
    vecs[8]  = mk(0, 4'b0010, 64'h0, 1, 4'b0010, 1, 32'h0000_0000, 2'd1);
    // ptr=2 wrapped past 1: 0 wins, then 1; extreme regimes
    vecs[9]  = mk(0, 4'b0011, {32'h0, 16'h0001, 16'h7FFF}, 1, 4'b0001, 1, 32'h4680_0000, 2'd0);
    vecs[10] = mk(0, 4'b0011, {32'h0, 16'h0001, 16'h7FFF}, 1, 4'b0010, 1, 32'h3880_0000, 2'd1);
    // idle: result consumed, data held
    vecs[11] = mk(0, 4'b0000, 64'h0, 1, 4'b0000, 0, 32'h3880_0000, 2'd1);
    // backpressure: load into empty slot, then 5 stalled cycles
    vecs[12] = mk(0, 4'hF, rr4, 0, 4'b0100, 1, 32'h4000_0000, 2'd2);
    for (int i = 13; i <= 17; i++)
      vecs[i] = mk(0, 4'hF, rr4, 0, 4'b0000, 1, 32'h4000_0000, 2'd2);
    // release: consume id2 and load id3 in the same edge
    vecs[18] = mk(0, 4'hF, rr4, 1, 4'b1000, 1, 32'h3FC0_0000, 2'd3);
    vecs[19] = mk(0, 4'b0000, rr4, 1, 4'b0000, 0, 32'h3FC0_0000, 2'd3);
    // negative with negative regime and fraction; fraction truncated to 8 bits
    vecs[20] = mk(0, 4'b0001, {48'h0, 16'hCC00}, 1, 4'b0001, 1, 32'hBF50_0000, 2'd0);
    vecs[21] = mk(0, 4'b0010, {32'h0, 16'h4001, 16'h0}, 1, 4'b0010, 1, 32'h3F80_0000, 2'd1);

    prev_ov = 1'b0;
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].rv, vecs[i].p, vecs[i].ordy);
      check($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(vecs[i].e_rdy));
      check($sformatf("v%0d busy", i), 32'(busy), 32'(prev_ov || (|vecs[i].rv)));
      @(posedge clk); #1;
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      if (vecs[i].e_ov || i >= 11) begin
        check($sformatf("v%0d out_fp32", i), out_fp32, vecs[i].e_fp);
        check($sformatf("v%0d out_id", i), 32'(out_id), 32'(vecs[i].e_id));
      end
      prev_ov = vecs[i].e_ov;
    end

    // bounded wait for a lone request from 3 (ptr=2 here)
    drive(0, 4'b1000, {16'h6000, 48'h0}, 1);
    check("lone3 req_ready", 32'(req_ready), 32'h8);
    got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(posedge clk); #1;
      req_valid = '0;
      if (out_valid) got = 1'b1;
    end
    check("lone3 out_valid within budget", 32'(got), 32'h1);
    check("lone3 out_fp32", out_fp32, 32'h4000_0000);
    check("lone3 out_id", 32'(out_id), 32'd3);

    // move ptr to 1, then stall with a held result and reset mid-transfer
    drive(0, 4'b0001, {48'h0, 16'h4000}, 1);
    @(posedge clk); #1;
    check("pre-rst out_id", 32'(out_id), 32'd0);
    drive(0, 4'hF, rr4, 0);
    check("stall req_ready", 32'(req_ready), 32'h0);
    drive(1, 4'hF, rr4, 0);
    check("rst-cycle req_ready", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    check("midrst out_valid", 32'(out_valid), 32'h0);
    check("midrst out_fp32", out_fp32, 32'h0);
    check("midrst out_id", 32'(out_id), 32'd0);
    for (int c = 0; c < 2; c++) begin
      drive(0, 4'b0000, 64'h0, 1);
      @(posedge clk); #1;
      check($sformatf("discarded result stays gone %0d", c), 32'(out_valid), 32'h0);
    end
    // ptr back at 0: requester 0 beats 1
    drive(0, 4'b0011, {32'h0, 16'hC000, 16'h5000}, 1);
    check("post-rst grant", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    check("post-rst out_fp32", out_fp32, 32'h3FC0_0000);
    check("post-rst out_id", 32'(out_id), 32'd0);
    drive(0, 4'b0000, 64'h0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
